st2bus: RTL and testbench
=========================

ST2BUS -- requirements
Module: st2bus

Interface
REQ-001 SHALL have parameter BUS, default 512: output bus word width in bits.
REQ-002 SHALL have parameter ST, default 8: Avalon-ST sample width; BUS SHALL be an integer multiple of ST.
REQ-003 SHALL have parameter NUM_ST_PER_BUS, default 64 (BUS/ST): samples packed per bus word.
REQ-004 SHALL have parameter ST_PER_TURBO_PKT, default 1024: expected samples per turbo packet.
REQ-005 SHALL have port clk_400  input  1: sole clock; all logic on its rising edge.
REQ-006 SHALL have port rst_n  input  1: synchronous, active-low reset.
REQ-007 SHALL have ports st_data  input  ST; st_valid, st_sop, st_eop, st_error  input  1 each: Avalon-ST sink from the turbo decoder.
REQ-008 SHALL have port st_ready  output  1: sink ready.
REQ-009 SHALL have port bus_data  output  BUS: packed word.
REQ-010 SHALL have ports bus_valid, bus_last, bus_err  output  1 each: word valid, last word of packet, packet errored.
REQ-011 SHALL have port bus_ready  input  1: downstream memory writer accepts the word.
REQ-012 SHALL have port len_err  output  1: sticky packet-length mismatch flag.

Function
REQ-013 Beat accepted SHALL mean st_valid && st_ready in the same cycle; word popped SHALL mean bus_valid && bus_ready.
REQ-014 Packing SHALL be LSB-first: first sample of a word in bits [ST-1:0], sample k in bits [(k+1)*ST-1 : k*ST].
REQ-015 Completed words SHALL enter a 2-entry output FIFO; bus_data/bus_valid/bus_last/bus_err SHALL reflect the FIFO head.
REQ-016 st_ready SHALL equal (FIFO occupancy < 2), combinationally from registered state.
REQ-017 A word SHALL be written to the FIFO in the cycle of the accepted beat that fills sample slot NUM_ST_PER_BUS-1; bus_valid SHALL rise the next cycle if the FIFO was empty (latency 1).
REQ-018 Simultaneous FIFO write and pop SHALL keep occupancy unchanged; occupancy SHALL never exceed 2 nor underflow.
REQ-019 State machine SHALL have states IDLE and PACK; reset state IDLE.
REQ-020 IDLE: accepted beats without st_sop SHALL be discarded; accepted beat with st_sop SHALL be stored in slot 0 and move to PACK.
REQ-021 PACK: accepted beats SHALL fill successive slots; slot index SHALL wrap to 0 after each full word.
REQ-022 Accepted beat with st_eop SHALL write the current word (unfilled upper slots zero) with bus_last=1, reset slot index to 0, return to IDLE.
REQ-023 Beat with st_sop and st_eop together SHALL produce one single-sample word with bus_last=1.
REQ-024 Accepted st_sop while in PACK (missing eop) SHALL write the open partial word zero-padded with bus_last=1, bus_err=1, then start a new packet with that beat in slot 0 of a fresh word; if the open word has zero filled slots, nothing SHALL be written for the old packet.
REQ-025 Any accepted beat with st_error=1 SHALL mark the packet errored; its bus_last word SHALL carry bus_err=1; non-last words SHALL carry bus_err=0.
REQ-026 Sample count per packet SHALL be a 14-bit counter saturating at 16383.

Reset
REQ-027 While rst_n=0 at a clock edge: FIFO empty, state IDLE, slot index 0, pack register 0, counters 0, len_err 0.
REQ-028 Reset values: bus_valid=0, bus_last=0, bus_err=0, bus_data=0, st_ready=1 from the first cycle after reset release.
REQ-029 Reset mid-packet SHALL discard all partial and buffered words; no word SHALL be emitted for that packet.

Configuration
REQ-030 With macro ST2BUS_LEN_CHECK_EN defined: at eop, sample count != ST_PER_TURBO_PKT SHALL force bus_err=1 on the last word and set len_err, which stays 1 until reset.
REQ-031 Without ST2BUS_LEN_CHECK_EN: no length check, len_err tied 0, bus_err per REQ-024/REQ-025 only.

Verification
REQ-032 1024 samples 0..1023 (8-bit wrap), bus_ready=1 -> 16 words, word0 bits[7:0]=0x00, bits[511:504]=0x3F, bus_last only on word 15, bus_err=0.
REQ-033 Same packet, bus_ready=0 -> st_ready falls after 128 accepted beats (2 words buffered); raising bus_ready resumes with no lost or duplicated samples.
REQ-034 Packet of 70 samples -> 2 words, word1 holds 6 samples in bits[47:0], bits[511:48]=0, bus_last=1; len_err=1 and bus_err=1 with ST2BUS_LEN_CHECK_EN, both 0 without.
REQ-035 sop, 10 samples, sop again, 1024 samples, eop -> first word bus_last=1 bus_err=1 with 10 samples; then 16 clean words.
REQ-036 st_error=1 on sample 500 of a 1024 packet -> only word 15 has bus_err=1; rst_n=0 at sample 300 of next packet -> bus_valid=0 next cycle, no further words until new sop.

Source files
------------

// File: rtl/st2bus.sv
// Packs Avalon-ST samples LSB-first into wide bus words behind a 2-entry FIFO.
// Optional length check at eop is enabled by defining ST2BUS_LEN_CHECK_EN.
module st2bus #(
    parameter int BUS              = 512,
    parameter int ST               = 8,
    parameter int NUM_ST_PER_BUS   = BUS / ST,
    parameter int ST_PER_TURBO_PKT = 1024
) (
    input  logic           clk_400,
    input  logic           rst_n,
    input  logic [ST-1:0]  st_data,
    input  logic           st_valid,
    input  logic           st_sop,
    input  logic           st_eop,
    input  logic           st_error,
    output logic           st_ready,
    output logic [BUS-1:0] bus_data,
    output logic           bus_valid,
    output logic           bus_last,
    output logic           bus_err,
    input  logic           bus_ready,
    output logic           len_err
);

    localparam int SW = (NUM_ST_PER_BUS > 1) ? $clog2(NUM_ST_PER_BUS) : 1;
    localparam logic [SW-1:0] LAST_SLOT = SW'(NUM_ST_PER_BUS - 1);
    localparam logic [13:0] PKT_LEN = 14'(ST_PER_TURBO_PKT);
`ifdef ST2BUS_LEN_CHECK_EN
    localparam logic LEN_CHK = 1'b1;
`else
    localparam logic LEN_CHK = 1'b0;
`endif

    typedef enum logic {IDLE, PACK} state_t;

    state_t         state_q, state_d;
    logic [SW-1:0]  slot_q, slot_d;
    logic [BUS-1:0] pack_q, pack_d;
    logic [13:0]    cnt_q, cnt_d, cnt_inc;
    logic           perr_q, perr_d;
    logic           len_err_q, len_err_d;
    logic [BUS-1:0] mem_q [2];
    logic [BUS-1:0] mem_d [2];
    logic [1:0]     flast_q, flast_d;
    logic [1:0]     ferr_q, ferr_d;
    logic           wr_ptr_q, wr_ptr_d;
    logic           rd_ptr_q, rd_ptr_d;
    logic [1:0]     occ_q, occ_d;

    logic           accept, pop, start, eop_bad;
    logic           wr_en, wr_last, wr_err;
    logic [BUS-1:0] wr_data, cur_word, first_word;

    assign st_ready  = (occ_q != 2'd2);
    assign bus_valid = (occ_q != 2'd0);
    assign bus_data  = bus_valid ? mem_q[rd_ptr_q] : '0;
    assign bus_last  = bus_valid & flast_q[rd_ptr_q];
    assign bus_err   = bus_valid & ferr_q[rd_ptr_q];
    assign len_err   = len_err_q;
    assign accept    = st_valid & st_ready;
    assign pop       = bus_valid & bus_ready;

    always_comb begin
        cnt_inc = (cnt_q == 14'h3FFF) ? cnt_q : cnt_q + 14'd1;
        cur_word = pack_q;
        for (int k = 0; k < NUM_ST_PER_BUS; k++) begin
            if (slot_q == SW'(k)) cur_word[k*ST +: ST] = st_data;
        end
        first_word = '0;
        first_word[ST-1:0] = st_data;

        state_d = state_q;
        slot_d  = slot_q;
        pack_d  = pack_q;
        cnt_d   = cnt_q;
        perr_d  = perr_q;
        start   = 1'b0;
        eop_bad = 1'b0;
        wr_en   = 1'b0;
        wr_data = cur_word;
        wr_last = 1'b0;
        wr_err  = 1'b0;

        if (accept) begin
            unique case (state_q)
                IDLE: start = st_sop;
                PACK: begin
                    if (st_sop) begin
                        // Missing eop: flush the open partial word as errored
                        start = 1'b1;
                        if (slot_q != '0) begin
                            wr_en   = 1'b1;
                            wr_data = pack_q;
                            wr_last = 1'b1;
                            wr_err  = 1'b1;
                        end
                    end else begin
                        pack_d = cur_word;
                        cnt_d  = cnt_inc;
                        perr_d = perr_q | st_error;
                        if (st_eop || slot_q == LAST_SLOT) begin
                            wr_en   = 1'b1;
                            wr_data = cur_word;
                            wr_last = st_eop;
                            eop_bad = st_eop & LEN_CHK & (cnt_inc != PKT_LEN);
                            wr_err  = st_eop & (perr_q | st_error | eop_bad);
                            pack_d  = '0;
                            slot_d  = '0;
                        end else begin
                            slot_d = slot_q + 1'b1;
                        end
                        if (st_eop) state_d = IDLE;
                    end
                end
            endcase

            if (start) begin
                cnt_d  = 14'd1;
                perr_d = st_error;
                if (st_eop || NUM_ST_PER_BUS == 1) begin
                    pack_d  = '0;
                    slot_d  = '0;
                    state_d = st_eop ? IDLE : PACK;
                    // A lone sop+eop colliding with a flush is dropped
                    if (!wr_en) begin
                        wr_en   = 1'b1;
                        wr_data = first_word;
                        wr_last = st_eop;
                        eop_bad = st_eop & LEN_CHK & (PKT_LEN != 14'd1);
                        wr_err  = st_eop & (st_error | eop_bad);
                    end
                end else begin
                    pack_d  = first_word;
                    slot_d  = SW'(1);
                    state_d = PACK;
                end
            end
        end

        len_err_d = len_err_q | eop_bad;

        mem_d    = mem_q;
        flast_d  = flast_q;
        ferr_d   = ferr_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        if (wr_en) begin
            mem_d[wr_ptr_q]   = wr_data;
            flast_d[wr_ptr_q] = wr_last;
            ferr_d[wr_ptr_q]  = wr_err;
            wr_ptr_d          = ~wr_ptr_q;
        end
        if (pop) rd_ptr_d = ~rd_ptr_q;
        unique case ({wr_en, pop})
            2'b10:   occ_d = occ_q + 2'd1;
            2'b01:   occ_d = occ_q - 2'd1;
            default: occ_d = occ_q;
        endcase
    end

    always_ff @(posedge clk_400) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            slot_q    <= '0;
            pack_q    <= '0;
            cnt_q     <= '0;
            perr_q    <= 1'b0;
            len_err_q <= 1'b0;
            mem_q[0]  <= '0;
            mem_q[1]  <= '0;
            flast_q   <= '0;
            ferr_q    <= '0;
            wr_ptr_q  <= 1'b0;
            rd_ptr_q  <= 1'b0;
            occ_q     <= '0;
        end else begin
            state_q   <= state_d;
            slot_q    <= slot_d;
            pack_q    <= pack_d;
            cnt_q     <= cnt_d;
            perr_q    <= perr_d;
            len_err_q <= len_err_d;
            mem_q     <= mem_d;
            flast_q   <= flast_d;
            ferr_q    <= ferr_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            occ_q     <= occ_d;
        end
    end

endmodule

// File: tb/tb_st2bus.sv
// Directed bench for st2bus: packing, backpressure, eop/sop/error handling, reset.
// Expectations follow ST2BUS_LEN_CHECK_EN when it is defined.
module tb_st2bus;

    localparam int BUS = 512;
    localparam int ST  = 8;
`ifdef ST2BUS_LEN_CHECK_EN
    localparam int LEN = 1;
`else
    localparam int LEN = 0;
`endif

    logic           clk_400 = 1'b0;
    logic           rst_n;
    logic [ST-1:0]  st_data;
    logic           st_valid, st_sop, st_eop, st_error, st_ready;
    logic [BUS-1:0] bus_data;
    logic           bus_valid, bus_last, bus_err, bus_ready, len_err;

    always #5 clk_400 = ~clk_400;

    st2bus #(
        .BUS(BUS), .ST(ST), .NUM_ST_PER_BUS(64), .ST_PER_TURBO_PKT(1024)
    ) dut (
        .clk_400(clk_400), .rst_n(rst_n),
        .st_data(st_data), .st_valid(st_valid), .st_sop(st_sop),
        .st_eop(st_eop), .st_error(st_error), .st_ready(st_ready),
        .bus_data(bus_data), .bus_valid(bus_valid), .bus_last(bus_last),
        .bus_err(bus_err), .bus_ready(bus_ready), .len_err(len_err)
    );

    typedef struct {
        logic [BUS-1:0] data;
        logic           last;
        logic           err;
    } word_t;

    word_t q[$];
    int    acc_cnt = 0;
    int    n_chk = 0;
    int    n_fail = 0;

    always @(negedge clk_400) begin
        if (rst_n === 1'b1) begin
            if (bus_valid && bus_ready) q.push_back('{bus_data, bus_last, bus_err});
            if (st_valid && st_ready) acc_cnt++;
        end
    end

    task automatic chk_w(input string tag, input logic [BUS-1:0] obs, input logic [BUS-1:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_i(input string tag, input int obs, input int exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [BUS-1:0] mk_word(input int base, input int n);
        logic [BUS-1:0] w;
        w = '0;
        for (int k = 0; k < n; k++) w[k*ST +: ST] = ST'(base + k);
        return w;
    endfunction

    task automatic send(input logic [ST-1:0] d, input logic sop, input logic eop, input logic err);
        int guard;
        @(posedge clk_400);
        #1;
        st_valid = 1'b1;
        st_data  = d;
        st_sop   = sop;
        st_eop   = eop;
        st_error = err;
        guard = 0;
        while (!st_ready && guard < 1000) begin
            @(posedge clk_400);
            #1;
            guard++;
        end
        if (guard >= 1000) chk_i("send_timeout", int'(st_ready), 1);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk_400);
            #1;
            st_valid = 1'b0;
            st_sop   = 1'b0;
            st_eop   = 1'b0;
            st_error = 1'b0;
        end
    endtask

    task automatic send_pkt(input int n, input int base, input logic sop1, input logic eopn, input int err_at);
        for (int i = 0; i < n; i++)
            send(ST'(base + i), sop1 && i == 0, eopn && i == n - 1, i == err_at);
    endtask

    task automatic chk_pkt(input string tag, input int off, input logic err_last);
        for (int w = 0; w < 16; w++) begin
            chk_w($sformatf("%s_d%0d", tag, w), q[off+w].data, mk_word(w * 64, 64));
            chk_i($sformatf("%s_l%0d", tag, w), int'(q[off+w].last), int'(w == 15));
            chk_i($sformatf("%s_e%0d", tag, w), int'(q[off+w].err), int'(w == 15 && err_last));
        end
    endtask

    initial begin
        rst_n = 1'b0; bus_ready = 1'b1;
        st_valid = 1'b0; st_data = '0; st_sop = 1'b0; st_eop = 1'b0; st_error = 1'b0;
        repeat (3) @(posedge clk_400);
        #1 rst_n = 1'b1;
        @(negedge clk_400);
        chk_i("rst_valid", int'(bus_valid), 0);
        chk_i("rst_last", int'(bus_last), 0);
        chk_i("rst_err", int'(bus_err), 0);
        chk_w("rst_data", bus_data, '0);
        chk_i("rst_ready", int'(st_ready), 1);
        chk_i("rst_len_err", int'(len_err), 0);

        send_pkt(1024, 0, 1, 1, -1);
        idle(10);
        chk_i("p1_words", q.size(), 16);
        chk_i("p1_w0_lo", int'(q[0].data[7:0]), 'h00);
        chk_i("p1_w0_hi", int'(q[0].data[511:504]), 'h3F);
        chk_pkt("p1", 0, 1'b0);
        chk_i("p1_len_err", int'(len_err), 0);
        q.delete();

        bus_ready = 1'b0;
        acc_cnt = 0;
        send_pkt(128, 0, 1, 0, -1);
        @(posedge clk_400);
        #1 st_valid = 1'b0;
        chk_i("bp_ready_low", int'(st_ready), 0);
        chk_i("bp_acc128", acc_cnt, 128);
        chk_i("bp_valid", int'(bus_valid), 1);
        idle(5);
        chk_i("bp_hold", acc_cnt, 128);
        chk_i("bp_no_pop", q.size(), 0);
        bus_ready = 1'b1;
        send_pkt(896, 128, 0, 1, -1);
        idle(10);
        chk_i("bp_acc_all", acc_cnt, 1024);
        chk_i("bp_words", q.size(), 16);
        chk_pkt("bp", 0, 1'b0);
        q.delete();

        send_pkt(70, 0, 1, 1, -1);
        idle(10);
        chk_i("s70_words", q.size(), 2);
        chk_w("s70_d0", q[0].data, mk_word(0, 64));
        chk_i("s70_l0", int'(q[0].last), 0);
        chk_i("s70_e0", int'(q[0].err), 0);
        chk_w("s70_d1", q[1].data, mk_word(64, 6));
        chk_i("s70_l1", int'(q[1].last), 1);
        chk_i("s70_e1", int'(q[1].err), LEN);
        chk_i("s70_len_err", int'(len_err), LEN);
        q.delete();

        send_pkt(10, 'hA0, 1, 0, -1);
        send_pkt(1024, 0, 1, 1, -1);
        idle(10);
        chk_i("ms_words", q.size(), 17);
        chk_w("ms_d0", q[0].data, mk_word('hA0, 10));
        chk_i("ms_l0", int'(q[0].last), 1);
        chk_i("ms_e0", int'(q[0].err), 1);
        chk_pkt("ms", 1, 1'b0);
        q.delete();

        send_pkt(1024, 0, 1, 1, 500);
        idle(10);
        chk_i("er_words", q.size(), 16);
        chk_pkt("er", 0, 1'b1);
        q.delete();

        send_pkt(300, 0, 1, 0, -1);
        @(posedge clk_400);
        #1 st_valid = 1'b0;
        rst_n = 1'b0;
        chk_i("mr_pre_words", q.size(), 4);
        @(posedge clk_400);
        #1;
        chk_i("mr_valid", int'(bus_valid), 0);
        chk_i("mr_ready", int'(st_ready), 1);
        chk_i("mr_len_err", int'(len_err), 0);
        q.delete();
        rst_n = 1'b1;
        send_pkt(100, 'h10, 0, 0, -1);
        idle(5);
        chk_i("mr_nosop_words", q.size(), 0);
        chk_i("mr_nosop_valid", int'(bus_valid), 0);
        send('h5A, 1, 1, 0);
        idle(5);
        chk_i("se_words", q.size(), 1);
        chk_w("se_d", q[0].data, mk_word('h5A, 1));
        chk_i("se_l", int'(q[0].last), 1);
        chk_i("se_e", int'(q[0].err), LEN);
        chk_i("se_len_err", int'(len_err), LEN);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
